pkt_deframer: RTL and testbench
===============================

PKT_DEFRAMER -- requirements
Module: pkt_deframer

Interface
REQ-001 Parameter REQ_ID_WIDTH, default 32: width of the request ID carried in header and footer beats.
REQ-002 Parameter BEATS_PER_PACKET, default 32: number of data beats between header and footer.
REQ-003 clk  input  1  clock; all logic is rising-edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 AXIS_RX_TDATA  input  512  framed stream: header beat, BEATS_PER_PACKET data beats, footer beat.
REQ-006 AXIS_RX_TVALID  input  1 / AXIS_RX_TREADY  output  1  RX handshake.
REQ-007 AXIS_TX_TDATA  output  512  data beats only; header and footer are stripped.
REQ-008 AXIS_TX_TVALID  output  1 / AXIS_TX_TLAST  output  1 / AXIS_TX_TREADY  input  1  TX handshake; TLAST marks the last data beat.
REQ-009 REQ_ID_OUT  output  REQ_ID_WIDTH  header ID of the most recently completed packet.
REQ-010 REQ_ID_VALID  output  1  one-cycle strobe qualifying REQ_ID_OUT.
REQ-011 CLR_STATS  input  1  one-cycle pulse that clears the counters and sticky flags.
REQ-012 FOOTER_ERR  output  1  sticky flag: a footer ID did not match its header ID.
REQ-013 SEQ_ERR  output  1  sticky flag: a header ID was not the previous header ID + 1.
REQ-014 PKT_COUNT  output  32  count of completed packets.
REQ-015 ERR_COUNT  output  16  count of footer mismatches.

Function
REQ-016 States: S_HDR, S_DATA, S_FTR.
REQ-017 S_HDR: AXIS_RX_TREADY is 1.
  - On handshake, capture TDATA[REQ_ID_WIDTH-1:0] as hdr_id.
  - Load beat counter with BEATS_PER_PACKET.
  - Go to S_DATA.
REQ-018 S_DATA: AXIS_RX_TREADY = !AXIS_TX_TVALID || AXIS_TX_TREADY.
REQ-019 S_DATA handshake: register the beat into the TX output register with TVALID=1 on the next cycle, so latency is 1 cycle.
REQ-020 S_DATA beat counting:
  - Decrement the counter on each handshake.
  - The beat accepted when the counter equals 1 carries TLAST=1; the state then goes to S_FTR.
REQ-021 TX register: TVALID clears on a TX handshake with no new RX beat in the same cycle. TDATA and TLAST hold stable while TVALID=1 and TREADY=0.
REQ-022 S_FTR: AXIS_RX_TREADY is 1. On handshake:
  - Compare TDATA[REQ_ID_WIDTH-1:0] with hdr_id. On mismatch, set FOOTER_ERR and increment ERR_COUNT, saturating at 0xFFFF.
  - Increment PKT_COUNT, wrapping modulo 2^32.
  - Drive REQ_ID_OUT=hdr_id and pulse REQ_ID_VALID on the next cycle.
  - Go to S_HDR.
REQ-023 Header and footer beats never appear on TX; they are accepted even while a TX beat is stalled.
REQ-024 CLR_STATS zeroes PKT_COUNT, ERR_COUNT, FOOTER_ERR and SEQ_ERR. If CLR_STATS coincides with an increment or a flag set, the clear wins. CLR_STATS does not affect framing state.
REQ-025 A TVALID=0 gap in any state stalls the state machine with no state change.

Reset
REQ-026 On resetn=0 at a clock edge:
  - state=S_HDR.
  - AXIS_TX_TVALID=0, AXIS_TX_TLAST=0.
  - REQ_ID_VALID=0, REQ_ID_OUT=0.
  - PKT_COUNT=0, ERR_COUNT=0, FOOTER_ERR=0, SEQ_ERR=0.
  - Previous-ID-valid flag = 0.
REQ-027 AXIS_RX_TREADY is 0 while resetn=0.
REQ-028 Reset mid-packet discards the partial packet; the first beat after reset is treated as a header.
REQ-029 AXIS_TX_TDATA and hdr_id are not reset.

Configuration
REQ-030 Macro SEQ_CHECK_EN.
  - Defined: each header ID is compared with the previous header ID + 1, modulo 2^REQ_ID_WIDTH. A mismatch sets SEQ_ERR.
  - The first header after reset or CLR_STATS is never flagged; it only seeds the previous ID.
REQ-031 Undefined: SEQ_ERR is tied to 0 and no sequence logic is built. All other behaviour is unchanged.

Verification
REQ-032 Packet header 0x5, data beats 1..32, footer 0x5, TX_TREADY=1 -> 32 TX beats 1..32 with TLAST only on beat 32; REQ_ID_OUT=5 strobed; PKT_COUNT=1; FOOTER_ERR=0.
REQ-033 Header 0x7, footer 0x8 -> FOOTER_ERR=1 and ERR_COUNT=1; data still forwarded intact; PKT_COUNT increments.
REQ-034 TX_TREADY toggling 1-0-0-1 during data -> no beat lost or duplicated; TDATA stable while stalled; RX_TREADY=0 while the TX register is full and stalled.
REQ-035 resetn=0 after data beat 10, then a full packet with ID 0x9 -> only the 0x9 packet appears on TX; PKT_COUNT=1.
REQ-036 SEQ_CHECK_EN defined, headers 3, 4, 6 -> SEQ_ERR=0 after 4 and SEQ_ERR=1 after 6. Header 0xFFFFFFFF followed by 0 -> no error. Macro undefined -> SEQ_ERR stays 0.
REQ-037 CLR_STATS in the same cycle as a footer mismatch -> ERR_COUNT=0 and FOOTER_ERR=0 afterwards.

Source files
------------

// File: rtl/pkt_deframer.sv
// Strips header/footer beats from a framed AXI-Stream and forwards the data beats with TLAST.
// Tracks packet/footer-error statistics; define SEQ_CHECK_EN to also check header ID sequencing.
module pkt_deframer #(
  parameter int REQ_ID_WIDTH     = 32,
  parameter int BEATS_PER_PACKET = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [511:0]            AXIS_RX_TDATA,
  input  logic                    AXIS_RX_TVALID,
  output logic                    AXIS_RX_TREADY,
  output logic [511:0]            AXIS_TX_TDATA,
  output logic                    AXIS_TX_TVALID,
  output logic                    AXIS_TX_TLAST,
  input  logic                    AXIS_TX_TREADY,
  output logic [REQ_ID_WIDTH-1:0] REQ_ID_OUT,
  output logic                    REQ_ID_VALID,
  input  logic                    CLR_STATS,
  output logic                    FOOTER_ERR,
  output logic                    SEQ_ERR,
  output logic [31:0]             PKT_COUNT,
  output logic [15:0]             ERR_COUNT
);

  localparam int CNT_W = $clog2(BEATS_PER_PACKET + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BEATS_PER_PACKET);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] S_HDR  = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_FTR  = 2'd2;

  logic [1:0]              state_reg;
  logic [CNT_W-1:0]        beat_cnt_reg;
  logic [REQ_ID_WIDTH-1:0] hdr_id_reg;
  logic [511:0]            tx_data_reg;
  logic                    tx_valid_reg;
  logic                    tx_last_reg;
  logic [REQ_ID_WIDTH-1:0] req_id_reg;
  logic                    req_id_valid_reg;
  logic [31:0]             pkt_count_reg;
  logic [15:0]             err_count_reg;
  logic                    footer_err_reg;

  logic                    rx_ready;
  logic                    rx_fire;
  logic                    hdr_fire;
  logic                    data_fire;
  logic                    ftr_fire;
  logic                    last_beat;
  logic                    id_mismatch;
  logic [REQ_ID_WIDTH-1:0] rx_id;

  // Header and footer are always accepted; data only when the TX register can take it.
  always_comb begin
    rx_ready = 1'b0;
    if (resetn) begin
      if (state_reg == S_DATA) rx_ready = !tx_valid_reg || AXIS_TX_TREADY;
      else                     rx_ready = 1'b1;
    end
  end

  assign rx_fire     = AXIS_RX_TVALID && rx_ready;
  assign hdr_fire    = rx_fire && (state_reg == S_HDR);
  assign data_fire   = rx_fire && (state_reg == S_DATA);
  assign ftr_fire    = rx_fire && (state_reg == S_FTR);
  assign last_beat   = (beat_cnt_reg == CNT_ONE);
  assign rx_id       = AXIS_RX_TDATA[REQ_ID_WIDTH-1:0];
  assign id_mismatch = (rx_id != hdr_id_reg);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg    <= S_HDR;
      beat_cnt_reg <= '0;
    end else begin
      case (state_reg)
        S_HDR: begin
          if (rx_fire) begin
            beat_cnt_reg <= CNT_LOAD;
            state_reg    <= S_DATA;
          end
        end
        S_DATA: begin
          if (rx_fire) begin
            beat_cnt_reg <= beat_cnt_reg - CNT_ONE;
            if (last_beat) state_reg <= S_FTR;
          end
        end
        S_FTR: begin
          if (rx_fire) state_reg <= S_HDR;
        end
        default: state_reg <= S_HDR;
      endcase
    end
  end

  // Datapath registers without reset.
  always_ff @(posedge clk) begin
    if (hdr_fire)  hdr_id_reg  <= rx_id;
    if (data_fire) tx_data_reg <= AXIS_RX_TDATA;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tx_valid_reg <= 1'b0;
      tx_last_reg  <= 1'b0;
    end else if (data_fire) begin
      tx_valid_reg <= 1'b1;
      tx_last_reg  <= last_beat;
    end else if (AXIS_TX_TREADY) begin
      tx_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      req_id_reg       <= '0;
      req_id_valid_reg <= 1'b0;
    end else begin
      req_id_valid_reg <= ftr_fire;
      if (ftr_fire) req_id_reg <= hdr_id_reg;
    end
  end

  // Statistics: a clear pulse takes priority over any concurrent update.
  always_ff @(posedge clk) begin
    if (!resetn || CLR_STATS) begin
      pkt_count_reg  <= '0;
      err_count_reg  <= '0;
      footer_err_reg <= 1'b0;
    end else if (ftr_fire) begin
      pkt_count_reg <= pkt_count_reg + 32'd1;
      if (id_mismatch) begin
        footer_err_reg <= 1'b1;
        if (err_count_reg != 16'hFFFF) err_count_reg <= err_count_reg + 16'd1;
      end
    end
  end

`ifdef SEQ_CHECK_EN
  logic [REQ_ID_WIDTH-1:0] prev_id_reg;
  logic                    prev_valid_reg;
  logic                    seq_err_reg;

  // The first header after reset or a clear only seeds the previous ID.
  always_ff @(posedge clk) begin
    if (!resetn || CLR_STATS) begin
      prev_id_reg    <= '0;
      prev_valid_reg <= 1'b0;
      seq_err_reg    <= 1'b0;
    end else if (hdr_fire) begin
      prev_id_reg    <= rx_id;
      prev_valid_reg <= 1'b1;
      if (prev_valid_reg && (rx_id != prev_id_reg + REQ_ID_WIDTH'(1))) seq_err_reg <= 1'b1;
    end
  end

  assign SEQ_ERR = seq_err_reg;
`else
  assign SEQ_ERR = 1'b0;
`endif

  assign AXIS_RX_TREADY = rx_ready;
  assign AXIS_TX_TDATA  = tx_data_reg;
  assign AXIS_TX_TVALID = tx_valid_reg;
  assign AXIS_TX_TLAST  = tx_last_reg;
  assign REQ_ID_OUT     = req_id_reg;
  assign REQ_ID_VALID   = req_id_valid_reg;
  assign PKT_COUNT      = pkt_count_reg;
  assign ERR_COUNT      = err_count_reg;
  assign FOOTER_ERR     = footer_err_reg;

endmodule

// File: tb/tb_pkt_deframer.sv
// Self-checking bench for pkt_deframer: table-driven packets, hand-written corner sequences,
// and randomized traffic checked against a packet-level reference model.
module tb_pkt_deframer;
  localparam int W = 32;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [511:0] AXIS_RX_TDATA = '0;
  logic         AXIS_RX_TVALID = 1'b0;
  logic         AXIS_RX_TREADY;
  logic [511:0] AXIS_TX_TDATA;
  logic         AXIS_TX_TVALID;
  logic         AXIS_TX_TLAST;
  logic         AXIS_TX_TREADY = 1'b1;
  logic [W-1:0] REQ_ID_OUT;
  logic         REQ_ID_VALID;
  logic         CLR_STATS = 1'b0;
  logic         FOOTER_ERR;
  logic         SEQ_ERR;
  logic [31:0]  PKT_COUNT;
  logic [15:0]  ERR_COUNT;

  always #5 clk = ~clk;

  pkt_deframer #(.REQ_ID_WIDTH(W), .BEATS_PER_PACKET(N)) dut (
    .clk(clk), .resetn(resetn),
    .AXIS_RX_TDATA(AXIS_RX_TDATA), .AXIS_RX_TVALID(AXIS_RX_TVALID), .AXIS_RX_TREADY(AXIS_RX_TREADY),
    .AXIS_TX_TDATA(AXIS_TX_TDATA), .AXIS_TX_TVALID(AXIS_TX_TVALID), .AXIS_TX_TLAST(AXIS_TX_TLAST),
    .AXIS_TX_TREADY(AXIS_TX_TREADY), .REQ_ID_OUT(REQ_ID_OUT), .REQ_ID_VALID(REQ_ID_VALID),
    .CLR_STATS(CLR_STATS), .FOOTER_ERR(FOOTER_ERR), .SEQ_ERR(SEQ_ERR),
    .PKT_COUNT(PKT_COUNT), .ERR_COUNT(ERR_COUNT)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_wide(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Reference model: expected TX beats, expected ID strobes, expected statistics.
  logic [511:0] exp_data_q[$];
  bit           exp_last_q[$];
  logic [W-1:0] exp_id_q[$];
  int unsigned  m_pkt = 0;
  int unsigned  m_err = 0;
  bit           m_ferr = 0;
  bit           m_seq = 0;
  logic [W-1:0] m_prev = '0;
  bit           m_prev_v = 0;

  task automatic model_clear();
    m_pkt = 0; m_err = 0; m_ferr = 0; m_seq = 0; m_prev_v = 0;
  endtask

  // TX ready generator: 0 = always ready, 1 = random, 2 = repeating 1-0-0-1.
  int rdy_mode = 0;
  int pat_i = 0;
  bit gap_en = 0;
  bit in_data = 0;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1: AXIS_TX_TREADY = ($urandom_range(0, 2) != 0);
      2: begin
        AXIS_TX_TREADY = ((pat_i % 4) == 0) || ((pat_i % 4) == 3);
        pat_i++;
      end
      default: AXIS_TX_TREADY = 1'b1;
    endcase
  end

  // Monitor: TX beats against the model queue, stall stability, RX backpressure, ID strobes.
  bit           held_v = 0;
  logic [511:0] held_d;
  logic         held_l;

  always @(negedge clk) begin
    if (!resetn) begin
      held_v = 0;
    end else begin
      if (held_v) begin
        chk("tx_valid_held", AXIS_TX_TVALID, 1'b1);
        chk_wide("tx_data_held", AXIS_TX_TDATA, held_d);
        chk("tx_last_held", AXIS_TX_TLAST, held_l);
      end
      held_v = AXIS_TX_TVALID && !AXIS_TX_TREADY;
      held_d = AXIS_TX_TDATA;
      held_l = AXIS_TX_TLAST;
      if (in_data && AXIS_TX_TVALID && !AXIS_TX_TREADY)
        chk("rx_ready_stalled", AXIS_RX_TREADY, 1'b0);
      if (AXIS_TX_TVALID && AXIS_TX_TREADY) begin
        if (exp_data_q.size() == 0) begin
          n_checks++;
          $display("FAIL tx_extra: got beat %0h required none", AXIS_TX_TDATA[63:0]);
        end else begin
          chk_wide("tx_data", AXIS_TX_TDATA, exp_data_q.pop_front());
          chk("tx_last", AXIS_TX_TLAST, exp_last_q.pop_front());
        end
      end
      if (REQ_ID_VALID) begin
        if (exp_id_q.size() == 0) begin
          n_checks++;
          $display("FAIL req_id_extra: got %0h required no strobe", REQ_ID_OUT);
        end else begin
          chk("req_id_out", REQ_ID_OUT, exp_id_q.pop_front());
        end
      end
    end
  end

  task automatic send_beat(input logic [511:0] d, input bit clr);
    bit fired = 0;
    int gaps = gap_en ? $urandom_range(0, 2) : 0;
    repeat (gaps) begin
      AXIS_RX_TVALID = 1'b0;
      @(posedge clk); #1;
    end
    AXIS_RX_TDATA  = d;
    AXIS_RX_TVALID = 1'b1;
    CLR_STATS      = clr;
    for (int t = 0; t < 200 && !fired; t++) begin
      @(negedge clk);
      fired = AXIS_RX_TREADY;
      @(posedge clk); #1;
      CLR_STATS = 1'b0;
    end
    AXIS_RX_TVALID = 1'b0;
    if (!fired) fail_now("rx_accept");
  endtask

  // One framed packet; stop_after > 0 abandons it after that many data beats.
  task automatic send_packet(input logic [W-1:0] hdr, input logic [W-1:0] ftr,
                             input bit seq_data, input bit clr_at_ftr, input int stop_after);
    logic [511:0] d;
    send_beat({$urandom, 448'h0, 32'h0, hdr}, 1'b0);
`ifdef SEQ_CHECK_EN
    if (m_prev_v && hdr != m_prev + 1) m_seq = 1;
`endif
    m_prev = hdr; m_prev_v = 1;
    in_data = 1;
    for (int i = 0; i < N; i++) begin
      d = seq_data ? 512'(i + 1) : {16{$urandom}};
      send_beat(d, 1'b0);
      exp_data_q.push_back(d);
      exp_last_q.push_back(i == N - 1);
      if (stop_after == i + 1) begin
        in_data = 0;
        $display("packet hdr=%0h abandoned after %0d beats", hdr, stop_after);
        return;
      end
    end
    in_data = 0;
    send_beat({{15{$urandom}}, ftr}, clr_at_ftr);
    exp_id_q.push_back(hdr);
    if (clr_at_ftr) begin
      model_clear();
    end else begin
      m_pkt++;
      if (ftr != hdr) begin
        m_ferr = 1;
        if (m_err < 65535) m_err++;
      end
    end
    $display("packet hdr=%0h ftr=%0h clr=%0d pkt=%0d err=%0d", hdr, ftr, clr_at_ftr, PKT_COUNT, ERR_COUNT);
  endtask

  task automatic drain();
    bit done = 0;
    for (int t = 0; t < 1000 && !done; t++) begin
      if (exp_data_q.size() == 0 && exp_id_q.size() == 0 && !AXIS_TX_TVALID) done = 1;
      else begin @(posedge clk); #1; end
    end
    if (!done) fail_now("drain");
  endtask

  task automatic check_stats(input string tag);
    chk({tag, "_pkt_count"}, PKT_COUNT, m_pkt);
    chk({tag, "_err_count"}, ERR_COUNT, m_err);
    chk({tag, "_footer_err"}, FOOTER_ERR, m_ferr);
    chk({tag, "_seq_err"}, SEQ_ERR, m_seq);
  endtask

  task automatic clear_stats();
    CLR_STATS = 1'b1;
    @(posedge clk); #1;
    CLR_STATS = 1'b0;
    model_clear();
  endtask

  typedef struct {
    logic [W-1:0] hdr;
    logic [W-1:0] ftr;
    int           mode;
    int           exp_pkt;
    int           exp_err;
    bit           exp_ferr;
  } vec_t;

  vec_t vecs[4];
  logic [W-1:0] hdr_r;
  logic [W-1:0] ftr_r;
  bit           exp_seq6;

  initial begin
    vecs[0] = '{hdr: 32'h5, ftr: 32'h5, mode: 0, exp_pkt: 1, exp_err: 0, exp_ferr: 0};
    vecs[1] = '{hdr: 32'h6, ftr: 32'h6, mode: 2, exp_pkt: 2, exp_err: 0, exp_ferr: 0};
    vecs[2] = '{hdr: 32'h7, ftr: 32'h8, mode: 0, exp_pkt: 3, exp_err: 1, exp_ferr: 1};
    vecs[3] = '{hdr: 32'h8, ftr: 32'h8, mode: 1, exp_pkt: 4, exp_err: 1, exp_ferr: 1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rx_ready", AXIS_RX_TREADY, 1'b0);
    chk("rst_tx_valid", AXIS_TX_TVALID, 1'b0);
    chk("rst_tx_last", AXIS_TX_TLAST, 1'b0);
    chk("rst_req_id_valid", REQ_ID_VALID, 1'b0);
    chk("rst_req_id_out", REQ_ID_OUT, 32'h0);
    chk("rst_pkt_count", PKT_COUNT, 32'h0);
    chk("rst_err_count", ERR_COUNT, 16'h0);
    chk("rst_footer_err", FOOTER_ERR, 1'b0);
    chk("rst_seq_err", SEQ_ERR, 1'b0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Table-driven packets
    for (int i = 0; i < 4; i++) begin
      rdy_mode = vecs[i].mode;
      gap_en   = (vecs[i].mode != 0);
      send_packet(vecs[i].hdr, vecs[i].ftr, 1'b1, 1'b0, 0);
      drain();
      chk("tbl_pkt_count", PKT_COUNT, vecs[i].exp_pkt);
      chk("tbl_err_count", ERR_COUNT, vecs[i].exp_err);
      chk("tbl_footer_err", FOOTER_ERR, vecs[i].exp_ferr);
      check_stats("tbl_model");
    end

    // Header sequence checking: 3, 4 consecutive; 6 skips
    rdy_mode = 0; gap_en = 0;
`ifdef SEQ_CHECK_EN
    exp_seq6 = 1;
`else
    exp_seq6 = 0;
`endif
    clear_stats();
    send_packet(32'h3, 32'h3, 1'b0, 1'b0, 0);
    send_packet(32'h4, 32'h4, 1'b0, 1'b0, 0);
    drain();
    chk("seq_after_4", SEQ_ERR, 1'b0);
    send_packet(32'h6, 32'h6, 1'b0, 1'b0, 0);
    drain();
    chk("seq_after_6", SEQ_ERR, exp_seq6);
    check_stats("seq");

    // ID wrap is in sequence
    clear_stats();
    send_packet(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
    send_packet(32'h0, 32'h0, 1'b0, 1'b0, 0);
    drain();
    chk("seq_wrap", SEQ_ERR, 1'b0);
    check_stats("wrap");

    // Clear coinciding with a footer mismatch
    send_packet(32'h30, 32'h31, 1'b0, 1'b1, 0);
    drain();
    chk("clr_err_count", ERR_COUNT, 16'h0);
    chk("clr_footer_err", FOOTER_ERR, 1'b0);
    chk("clr_pkt_count", PKT_COUNT, 32'h0);

    // Reset after data beat 10, then a clean packet 0x9
    send_packet(32'h20, 32'h20, 1'b0, 1'b0, 10);
    drain();
    resetn = 1'b0;
    @(negedge clk);
    chk("midrst_rx_ready", AXIS_RX_TREADY, 1'b0);
    @(posedge clk); #1;
    resetn = 1'b1;
    model_clear();
    chk("midrst_tx_valid", AXIS_TX_TVALID, 1'b0);
    send_packet(32'h9, 32'h9, 1'b1, 1'b0, 0);
    drain();
    chk("midrst_pkt_count", PKT_COUNT, 32'h1);
    check_stats("midrst");

    // Randomized traffic against the model
    rdy_mode = 1; gap_en = 1;
    for (int p = 0; p < 8; p++) begin
      hdr_r = ($urandom_range(0, 2) == 0) ? W'($urandom) : m_prev + 1;
      ftr_r = ($urandom_range(0, 3) == 0) ? (hdr_r ^ (32'h1 << $urandom_range(0, 31))) : hdr_r;
      send_packet(hdr_r, ftr_r, 1'b0, 1'b0, 0);
      drain();
      check_stats("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
